// File: rtl/spi_responder_if.sv
// ---------------------------------------------------------------------------
// spi_responder_if
//   Bundle of the SPI pins and the local TX/RX word handshake for
//   spi_responder. Clock and reset stay outside as plain ports.
//
//   SPI side   : IN_SPI_clk, IN_SPI_mosi, IN_SPI_cs_n -> responder
//                OUT_SPI_miso                         <- responder
//   TX side    : IN_txData, IN_txValid -> responder, OUT_txReady <- responder
//   RX side    : OUT_rxData, OUT_rxBytes, OUT_rxValid <- responder
//   Status     : OUT_underrun, OUT_error, OUT_busy    <- responder
//
//   Modports: slave  = the responder itself
//             master = whatever drives the SPI pins and consumes the words
// ---------------------------------------------------------------------------
interface spi_responder_if #(
    parameter int WIDTH = 32
);
    localparam int RXB_W = $clog2(WIDTH / 8 + 1);

    logic             IN_SPI_clk;
    logic             IN_SPI_mosi;
    logic             IN_SPI_cs_n;
    logic             OUT_SPI_miso;
    logic [WIDTH-1:0] IN_txData;
    logic             IN_txValid;
    logic             OUT_txReady;
    logic [WIDTH-1:0] OUT_rxData;
    logic [RXB_W-1:0] OUT_rxBytes;
    logic             OUT_rxValid;
    logic             OUT_underrun;
    logic             OUT_error;
    logic             OUT_busy;

    modport slave (
        input  IN_SPI_clk, IN_SPI_mosi, IN_SPI_cs_n, IN_txData, IN_txValid,
        output OUT_SPI_miso, OUT_txReady, OUT_rxData, OUT_rxBytes,
               OUT_rxValid, OUT_underrun, OUT_error, OUT_busy
    );

    modport master (
        output IN_SPI_clk, IN_SPI_mosi, IN_SPI_cs_n, IN_txData, IN_txValid,
        input  OUT_SPI_miso, OUT_txReady, OUT_rxData, OUT_rxBytes,
               OUT_rxValid, OUT_underrun, OUT_error, OUT_busy
    );
endinterface

// File: rtl/spi_responder.sv
// ---------------------------------------------------------------------------
// spi_responder
//   SPI target (mode 0, MSB-first). SCLK, MOSI and CS are oversampled in the
//   local clk domain. Received words are handed to local logic with a
//   one-cycle valid strobe; transmit words come from a one-entry holding
//   register, with TX_IDLE shifted out when that register is empty.
//
//   clk   : local clock
//   rst   : asynchronous, active-low reset
//   bus   : spi_responder_if.slave (SPI pins, TX/RX handshake, status)
// ---------------------------------------------------------------------------
module spi_responder #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TX_IDLE     = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    spi_responder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RXB_W = $clog2(WIDTH / 8 + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    // ---------------- input synchronizers ----------------
    logic sclk_s, mosi_s, cs_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sclk_s = bus.IN_SPI_clk;
            assign mosi_s = bus.IN_SPI_mosi;
            assign cs_s   = bus.IN_SPI_cs_n;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;

            // CS resets to "low" so that a frame already in progress at reset
            // release never looks like a fresh CS fall.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sclk_q <= '0;
                    mosi_q <= '0;
                    cs_q   <= '0;
                end else begin
                    sclk_q <= (sclk_q << 1) | SYNC_STAGES'(bus.IN_SPI_clk);
                    mosi_q <= (mosi_q << 1) | SYNC_STAGES'(bus.IN_SPI_mosi);
                    cs_q   <= (cs_q   << 1) | SYNC_STAGES'(bus.IN_SPI_cs_n);
                end
            end

            assign sclk_s = sclk_q[SYNC_STAGES-1];
            assign mosi_s = mosi_q[SYNC_STAGES-1];
            assign cs_s   = cs_q[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------- edge detection ----------------
    logic sclk_prev, cs_prev;

    // NOTE: every register is written with <= so all flops update from the
    // same pre-edge values; blocking assignments here would chain them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;  // CS must be seen high before a fall counts
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    logic load_start, frame_end, bit_in, bit_out;

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        load_start = 1'b0;
        frame_end  = 1'b0;
        bit_in     = 1'b0;
        bit_out    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    load_start = 1'b1;
                end
            end
            ACTIVE: begin
                // CS rise wins over an SCLK rise in the same cycle.
                if (cs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else if (sclk_rise) begin
                    bit_in = 1'b1;
                end else if (sclk_fall) begin
                    bit_out = 1'b1;
                end
            end
        endcase
    end

    // ---------------- datapath ----------------
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_rx, shift_tx, hold_data, rx_data_q, part_mask;
    logic [RXB_W-1:0] rx_bytes_q;
    logic             hold_full, reload_pend, miso_q;
    logic             rx_valid_q, underrun_q, err_q;

    logic             word_done, do_load, tx_write;
    logic [WIDTH-1:0] load_word, rx_next;

    assign word_done = bit_in && (bit_cnt == CNT_W'(WIDTH - 1));
    assign do_load   = load_start | word_done;
    assign load_word = hold_full ? hold_data : TX_IDLE;
    assign rx_next   = {shift_rx[WIDTH-2:0], mosi_s};
    assign tx_write  = bus.IN_txValid & ~hold_full;

    // Keeps only the bits received in the current partial word.
    always_comb begin
        part_mask = '0;
        for (int i = 0; i < WIDTH; i++) part_mask[i] = (i < int'(bit_cnt));
    end

    // NOTE: the data registers are reset too; they are few flops and a known
    // value keeps rxData at zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            shift_rx    <= '0;
            shift_tx    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            reload_pend <= 1'b0;
            miso_q      <= 1'b1;
            rx_data_q   <= '0;
            rx_bytes_q  <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;

            // Load uses the holding register as it stood at the start of the
            // cycle; a same-cycle write below is kept for the next word.
            if (do_load) begin
                shift_tx   <= load_word;
                underrun_q <= ~hold_full;
                hold_full  <= 1'b0;
            end
            if (tx_write) begin
                hold_full <= 1'b1;
                hold_data <= bus.IN_txData;
            end

            if (load_start) begin
                miso_q      <= load_word[WIDTH-1];
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end

            if (bit_in) begin
                shift_rx <= rx_next;
                if (word_done) begin
                    bit_cnt     <= '0;
                    rx_valid_q  <= 1'b1;
                    rx_data_q   <= rx_next;
                    rx_bytes_q  <= RXB_W'(WIDTH / 8);
                    reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            // miso only moves on a falling edge: after a reload the new MSB is
            // presented without shifting.
            if (bit_out) begin
                if (reload_pend) begin
                    miso_q      <= shift_tx[WIDTH-1];
                    reload_pend <= 1'b0;
                end else begin
                    shift_tx <= {shift_tx[WIDTH-2:0], 1'b0};
                    miso_q   <= shift_tx[WIDTH-2];
                end
            end

            if (frame_end) begin
                miso_q  <= 1'b1;
                bit_cnt <= '0;
                if (bit_cnt[2:0] != 3'd0) begin
                    err_q <= 1'b1;
                end else if (bit_cnt != '0) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= shift_rx & part_mask;
                    rx_bytes_q <= RXB_W'(bit_cnt >> 3);
                end
            end
        end
    end

    assign bus.OUT_SPI_miso = miso_q;
    assign bus.OUT_txReady  = ~hold_full;
    assign bus.OUT_rxData   = rx_data_q;
    assign bus.OUT_rxBytes  = rx_bytes_q;
    assign bus.OUT_rxValid  = rx_valid_q;
    assign bus.OUT_underrun = underrun_q;
    assign bus.OUT_error    = err_q;
    assign bus.OUT_busy     = (state != IDLE);
endmodule

// File: tb/tb_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_responder
//   Self-checking bench for spi_responder (WIDTH=32, SYNC_STAGES=2).
//   Acts as SPI master and local TX/RX logic through spi_responder_if.
// ---------------------------------------------------------------------------
module tb_spi_responder;
    localparam int             W       = 32;
    localparam int             SYNC    = 2;
    localparam int             HALF    = 5;   // clk cycles per SCLK phase
    localparam logic [W-1:0]   TX_IDLE = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_responder_if #(.WIDTH(W)) spi ();

    spi_responder #(.WIDTH(W), .SYNC_STAGES(SYNC), .TX_IDLE(TX_IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (spi.slave)
    );

    int total = 0;
    int bad   = 0;

    // Strobe monitor: collects delivered words and counts pulses.
    logic [W-1:0] rxd_q[$];
    int           rxb_q[$];
    int           under_cnt = 0;
    int           err_cnt   = 0;

    always @(negedge clk) begin
        if (spi.OUT_rxValid === 1'b1) begin
            rxd_q.push_back(spi.OUT_rxData);
            rxb_q.push_back(int'(spi.OUT_rxBytes));
        end
        if (spi.OUT_underrun === 1'b1) under_cnt++;
        if (spi.OUT_error === 1'b1)    err_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " miso"},     spi.OUT_SPI_miso, 1);
        check({tag, " txReady"},  spi.OUT_txReady,  1);
        check({tag, " rxData"},   spi.OUT_rxData,   0);
        check({tag, " rxBytes"},  spi.OUT_rxBytes,  0);
        check({tag, " rxValid"},  spi.OUT_rxValid,  0);
        check({tag, " underrun"}, spi.OUT_underrun, 0);
        check({tag, " error"},    spi.OUT_error,    0);
        check({tag, " busy"},     spi.OUT_busy,     0);
    endtask

    task automatic write_tx(input logic [W-1:0] d);
        int n = 0;
        while (spi.OUT_txReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("txReady before write", spi.OUT_txReady, 1);
        spi.IN_txData  = d;
        spi.IN_txValid = 1'b1;
        @(negedge clk);
        spi.IN_txValid = 1'b0;
        @(negedge clk);
    endtask

    // One SCLK period; miso is sampled just before the rising edge. With hook
    // set, txValid is raised for exactly the cycle in which the responder
    // acts on this rising edge.
    task automatic sclk_bit(input logic b, input bit hook, input logic [W-1:0] hd, output logic m);
        spi.IN_SPI_mosi = b;
        repeat (HALF) @(negedge clk);
        m = spi.OUT_SPI_miso;
        spi.IN_SPI_clk = 1'b1;
        for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            if (hook && c == SYNC - 1) begin
                spi.IN_txData  = hd;
                spi.IN_txValid = 1'b1;
            end
            if (hook && c == SYNC) spi.IN_txValid = 1'b0;
        end
        spi.IN_SPI_clk = 1'b0;
    endtask

    task automatic spi_frame(input int nbits, input logic [127:0] mosi, input bit clash,
                             input int hook_bit, input logic [W-1:0] hook_data,
                             output logic [127:0] miso_bits);
        logic m;
        miso_bits = '0;
        spi.IN_SPI_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(mosi[nbits-1-i], i == hook_bit, hook_data, m);
            miso_bits = {miso_bits[126:0], m};
        end
        repeat (HALF) @(negedge clk);
        if (clash) begin
            // CS and SCLK rise together: the extra SCLK rise must be ignored.
            spi.IN_SPI_mosi = 1'b1;
            spi.IN_SPI_clk  = 1'b1;
            spi.IN_SPI_cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.IN_SPI_clk = 1'b0;
        end else begin
            spi.IN_SPI_cs_n = 1'b1;
        end
        repeat (2 * HALF) @(negedge clk);
    endtask

    typedef struct {
        int           nbits;
        logic [127:0] mosi;
        bit           preload;
        logic [W-1:0] tx;
        bit           clash;
        logic [127:0] exp_miso;
        int           exp_nrx;
        logic [W-1:0] exp_rx0;
        int           exp_b0;
        logic [W-1:0] exp_rx1;
        int           exp_under;
        int           exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [127:0] mi, mo, exp_mi, mask;
        logic [W-1:0] last_rx;
        logic [W-1:0] words[$];
        logic [W-1:0] erx[$];
        int           erb[$];
        int           u0, e0, n0, nb, r, eu, ee;
        bit           m_full;
        logic [W-1:0] m_val, d;
        logic         m;
        string        tag;

        // Each load (CS fall and every completed word) takes the holding
        // register or underruns, including the load after the final word.
        //          nbits mosi                    pre tx             clash miso                      nrx rx0            b0 rx1            und err
        vecs[0] = '{32, 128'h12345678,          1, 32'hA5C30F01, 0, 128'hA5C30F01,          1, 32'h12345678, 4, 32'h0,        1, 0};
        vecs[1] = '{8,  128'h9C,                0, 32'h0,        0, 128'hFF,                1, 32'h0000009C, 1, 32'h0,        1, 0};
        vecs[2] = '{64, 128'hDEADBEEF_CAFEF00D, 1, 32'h3C3C1234, 0, 128'h3C3C1234_FFFFFFFF, 2, 32'hDEADBEEF, 4, 32'hCAFEF00D, 2, 0};
        vecs[3] = '{13, 128'h1ABC,              0, 32'h0,        0, 128'h1FFF,              0, 32'h0,        0, 32'h0,        1, 1};
        vecs[4] = '{8,  128'h5A,                1, 32'hC3000000, 0, 128'hC3,                1, 32'h0000005A, 1, 32'h0,        0, 0};
        vecs[5] = '{24, 128'hABCDEF,            0, 32'h0,        0, 128'hFFFFFF,            1, 32'h00ABCDEF, 3, 32'h0,        1, 0};
        vecs[6] = '{16, 128'hBEEF,              1, 32'h80017FFE, 1, 128'h8001,              1, 32'h0000BEEF, 2, 32'h0,        0, 0};
        vecs[7] = '{40, 128'h01_02030405,       1, 32'hF0E1D2C3, 0, 128'hF0E1D2C3_FF,       2, 32'h01020304, 4, 32'h00000005, 1, 0};

        rst             = 1'b0;
        spi.IN_SPI_clk  = 1'b0;
        spi.IN_SPI_mosi = 1'b0;
        spi.IN_SPI_cs_n = 1'b1;
        spi.IN_txData   = '0;
        spi.IN_txValid  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        last_rx = '0;

        // ---------------- table-driven frames ----------------
        foreach (vecs[k]) begin
            u0 = under_cnt;
            e0 = err_cnt;
            rxd_q.delete();
            rxb_q.delete();
            if (vecs[k].preload) write_tx(vecs[k].tx);
            spi_frame(vecs[k].nbits, vecs[k].mosi, vecs[k].clash, -1, '0, mi);
            tag = $sformatf("vec%0d", k);
            check({tag, " miso"},     mi, vecs[k].exp_miso);
            check({tag, " rx count"}, rxd_q.size(), vecs[k].exp_nrx);
            if (vecs[k].exp_nrx > 0 && rxd_q.size() > 0) begin
                check({tag, " rx0"},   rxd_q[0], vecs[k].exp_rx0);
                check({tag, " bytes0"}, rxb_q[0], vecs[k].exp_b0);
            end
            if (vecs[k].exp_nrx > 1 && rxd_q.size() > 1)
                check({tag, " rx1"}, rxd_q[1], vecs[k].exp_rx1);
            check({tag, " underruns"}, under_cnt - u0, vecs[k].exp_under);
            check({tag, " errors"},    err_cnt - e0,   vecs[k].exp_err);
            check({tag, " txReady"},   spi.OUT_txReady, 1);
            check({tag, " busy"},      spi.OUT_busy, 0);
            check({tag, " miso idle"}, spi.OUT_SPI_miso, 1);
            if (vecs[k].exp_nrx == 1) last_rx = vecs[k].exp_rx0;
            if (vecs[k].exp_nrx == 2) last_rx = vecs[k].exp_rx1;
            check({tag, " rxData held"}, spi.OUT_rxData, last_rx);
        end

        // ---------------- write in the same cycle as the word-1 reload ----------------
        u0 = under_cnt;
        rxd_q.delete();
        rxb_q.delete();
        write_tx(32'h11223344);
        spi_frame(40, 128'hA1_B2C3D4E5, 0, W - 1, 32'h55667788, mi);
        check("same-cycle write miso",     mi, 128'h11223344_FF);
        check("same-cycle write underrun", under_cnt - u0, 1);
        check("same-cycle write txReady",  spi.OUT_txReady, 0);
        check("same-cycle write rx count", rxd_q.size(), 2);
        u0 = under_cnt;
        spi_frame(8, 128'h00, 0, -1, '0, mi);
        check("held word next frame miso",     mi, 128'h55);
        check("held word next frame underrun", under_cnt - u0, 0);
        check("held word next frame txReady",  spi.OUT_txReady, 1);

        // ---------------- reset in the middle of a frame ----------------
        spi.IN_SPI_cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sclk_bit(1'($urandom_range(0, 1)), 0, '0, m);
            if (i == 5) write_tx(32'h00000077);
        end
        check("mid-frame busy", spi.OUT_busy, 1);
        check("mid-frame txReady", spi.OUT_txReady, 0);
        u0 = under_cnt;
        e0 = err_cnt;
        n0 = rxd_q.size();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("mid-frame reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) sclk_bit(1'b1, 0, '0, m);
        check("post-reset still idle", spi.OUT_busy, 0);
        spi.IN_SPI_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("post-reset no rx",       rxd_q.size() - n0, 0);
        check("post-reset no error",    err_cnt - e0, 0);
        check("post-reset no underrun", under_cnt - u0, 0);
        rxd_q.delete();
        rxb_q.delete();
        u0 = under_cnt;
        spi_frame(8, 128'h3E, 0, -1, '0, mi);
        check("post-reset frame miso",     mi, 128'hFF);
        check("post-reset frame underrun", under_cnt - u0, 1);
        check("post-reset frame rx count", rxd_q.size(), 1);
        if (rxd_q.size() > 0) begin
            check("post-reset frame rxData",  rxd_q[0], 32'h3E);
            check("post-reset frame rxBytes", rxb_q[0], 1);
        end

        // ---------------- randomized frames vs. reference model ----------------
        m_full = 1'b0;
        m_val  = '0;
        for (int f = 0; f < 24; f++) begin
            nb = $urandom_range(1, 80);
            mo = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1 && !m_full) begin
                d = $urandom;
                write_tx(d);
                m_full = 1'b1;
                m_val  = d;
            end

            // Words presented: one at CS fall plus one per completed word.
            words.delete();
            eu = 0;
            for (int k = 0; k <= nb / W; k++) begin
                if (m_full) begin
                    words.push_back(m_val);
                    m_full = 1'b0;
                end else begin
                    words.push_back(TX_IDLE);
                    eu++;
                end
            end
            exp_mi = '0;
            for (int i = 0; i < nb; i++) exp_mi = {exp_mi[126:0], words[i / W][W - 1 - (i % W)]};

            erx.delete();
            erb.delete();
            ee = 0;
            for (int k = 0; k < nb / W; k++) begin
                erx.push_back(W'(mo >> (nb - W * (k + 1))));
                erb.push_back(W / 8);
            end
            r = nb % W;
            if (r != 0) begin
                if (r % 8 == 0) begin
                    mask = (128'd1 << r) - 128'd1;
                    erx.push_back(W'(mo & mask));
                    erb.push_back(r / 8);
                end else begin
                    ee = 1;
                end
            end

            u0 = under_cnt;
            e0 = err_cnt;
            rxd_q.delete();
            rxb_q.delete();
            spi_frame(nb, mo, 0, -1, '0, mi);
            tag = $sformatf("rand%0d n=%0d", f, nb);
            check({tag, " miso"},      mi, exp_mi);
            check({tag, " rx count"},  rxd_q.size(), erx.size());
            for (int k = 0; k < erx.size(); k++) begin
                if (k < rxd_q.size()) begin
                    check({tag, " rxData"},  rxd_q[k], erx[k]);
                    check({tag, " rxBytes"}, rxb_q[k], erb[k]);
                end
            end
            check({tag, " underruns"}, under_cnt - u0, eu);
            check({tag, " errors"},    err_cnt - e0, ee);
            check({tag, " txReady"},   spi.OUT_txReady, !m_full);
            check({tag, " busy"},      spi.OUT_busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
